// File: rtl/branch_predict_unit_if.sv
// Fetch/decode-side signal bundle for branch_predict_unit.
// The pipeline side uses the master modport and the predictor uses the slave modport.
interface branch_predict_unit_if;
  logic        [31:0] if_pc;
  logic               pred_taken;
  logic        [31:0] pred_target;
  logic               id_branch;
  logic               id_stall;
  logic        [31:0] id_pc;
  logic               id_pred_taken;
  logic        [31:0] id_pred_target;
  logic               id_taken;
  logic        [31:0] id_target;
  logic               mispredict;
  logic        [31:0] redirect_pc;
  logic        [31:0] branch_cnt;
  logic        [31:0] mispred_cnt;

  modport master (
    output if_pc, id_branch, id_stall, id_pc, id_pred_taken, id_pred_target,
           id_taken, id_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, id_branch, id_stall, id_pc, id_pred_taken, id_pred_target,
           id_taken, id_target,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating counters. It predicts in IF, resolves against
// the ID comparator, trains the table, and counts branches and mispredicts.
module branch_predict_unit #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input logic               clk,
  input logic               reset,
  branch_predict_unit_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispred_cnt_q;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit, resolve, mispredict_c;

  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign if_tag = bp.if_pc[31:IDX_W+2];
  assign id_idx = bp.id_pc[IDX_W+1:2];
  assign id_tag = bp.id_pc[31:IDX_W+2];

  // The lookup reads the registered table, so an update on the same edge shows up on the next cycle.
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  assign bp.pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.if_pc + 32'd4;

  // Holding reset low also blocks resolution, so a bench held in reset sees no redirect.
  assign resolve      = reset && bp.id_branch && !bp.id_stall;
  assign mispredict_c = resolve && ((bp.id_taken != bp.id_pred_taken) ||
                        (bp.id_taken && (bp.id_pred_target != bp.id_target)));

  assign bp.mispredict  = mispredict_c;
  assign bp.redirect_pc = !reset ? 32'd0 :
                          (bp.id_taken ? bp.id_target : bp.id_pc + 32'd4);
  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (resolve) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_c && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      if (id_hit) begin
        if (bp.id_taken) begin
          if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'd1;
        end else begin
          if (ctr_q[id_idx] != 2'b00) ctr_q[id_idx] <= ctr_q[id_idx] - 2'd1;
        end
      end else if (bp.id_taken) begin
        valid_q[id_idx] <= 1'b1;
        ctr_q[id_idx]   <= CNT_INIT;
      end
    end
  end

  // Tags and targets are hidden by the valid bits, so they have no reset.
  // On a hit the tag already matches, so rewriting it is harmless.
  always_ff @(posedge clk) begin
    if (resolve && bp.id_taken) begin
      tag_q[id_idx]    <= id_tag;
      target_q[id_idx] <= bp.id_target;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit. Each stimulus step queues the expected outputs.
// A monitor compares them on the following falling edge.
module tb_branch_predict_unit;
  localparam logic [31:0] A   = 32'h0040_0010;
  localparam logic [31:0] A4  = 32'h0040_0014;
  localparam logic [31:0] T   = 32'h0040_0040;
  localparam logic [31:0] T80 = 32'h0040_0080;
  localparam logic [31:0] B   = 32'h0040_0110;
  localparam logic [31:0] B4  = 32'h0040_0114;
  localparam logic [31:0] TB  = 32'h0040_0200;
  localparam logic [31:0] M1  = 32'hFFFF_FFFF;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  branch_predict_unit_if bp();

  branch_predict_unit #(.IDX_W(6), .CNT_INIT(2'b10)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, exp finish before 100000");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({bp.pred_taken, bp.pred_target, bp.mispredict, bp.redirect_pc, bp.branch_cnt,
           bp.mispred_cnt} === {e.pt, e.ptg, e.mp, e.rd, e.bc, e.mc})
        passed++;
      else
        $display("FAIL %s: got pt=%0b ptg=%h mp=%0b rd=%h bc=%h mc=%h, exp pt=%0b ptg=%h mp=%0b rd=%h bc=%h mc=%h",
                 e.name, bp.pred_taken, bp.pred_target, bp.mispredict, bp.redirect_pc,
                 bp.branch_cnt, bp.mispred_cnt, e.pt, e.ptg, e.mp, e.rd, e.bc, e.mc);
    end
  end

  task automatic step(input string nm, input logic rs, input logic [31:0] ifpc,
                      input logic br, input logic st, input logic [31:0] idpc,
                      input logic ptk, input logic [31:0] ptgt, input logic tk,
                      input logic [31:0] tg, input logic e_pt, input logic [31:0] e_ptg,
                      input logic e_mp, input logic [31:0] e_rd, input logic [31:0] e_bc,
                      input logic [31:0] e_mc);
    exp_t e;
    reset             = rs;
    bp.if_pc          = ifpc;
    bp.id_branch      = br;
    bp.id_stall       = st;
    bp.id_pc          = idpc;
    bp.id_pred_taken  = ptk;
    bp.id_pred_target = ptgt;
    bp.id_taken       = tk;
    bp.id_target      = tg;
    e.name = nm; e.pt = e_pt; e.ptg = e_ptg; e.mp = e_mp;
    e.rd = e_rd; e.bc = e_bc; e.mc = e_mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] ifpc, input logic e_pt,
                      input logic [31:0] e_ptg, input logic [31:0] e_bc,
                      input logic [31:0] e_mc);
    step(nm, 1'b1, ifpc, 1'b0, 1'b0, A, 1'b0, A4, 1'b0, T, e_pt, e_ptg, 1'b0, A4, e_bc, e_mc);
  endtask

  initial begin
    bp.if_pc = A; bp.id_branch = 1'b0; bp.id_stall = 1'b0; bp.id_pc = A;
    bp.id_pred_taken = 1'b0; bp.id_pred_target = A4; bp.id_taken = 1'b0; bp.id_target = T;
    @(posedge clk);
    #1;
    step("reset_hold",  1'b0, A, 1, 0, A, 0, A4, 1, T,   0, A4,  0, 32'd0, 0, 0);
    step("alloc_miss",  1'b1, A, 1, 0, A, 0, A4, 1, T,   0, A4,  1, T,     0, 0);
    idle("hit_after_alloc", A, 1, T, 1, 1);
    step("nt1",         1'b1, A, 1, 0, A, 1, T,  0, T,   1, T,   1, A4,    1, 1);
    step("nt2",         1'b1, A, 1, 0, A, 0, A4, 0, T,   0, A4,  0, A4,    2, 2);
    step("tk1",         1'b1, A, 1, 0, A, 0, A4, 1, T,   0, A4,  1, T,     3, 2);
    step("tk2",         1'b1, A, 1, 0, A, 0, A4, 1, T,   0, A4,  1, T,     4, 3);
    idle("ctr2_taken", A, 1, T, 5, 4);
    step("stall",       1'b1, A, 1, 1, A, 1, T,  0, T,   1, T,   0, A4,    5, 4);
    idle("after_stall", A, 1, T, 5, 4);
    step("tgt_change",  1'b1, A, 1, 0, A, 1, T,  1, T80, 1, T,   1, T80,   5, 4);
    idle("new_target", A, 1, T80, 6, 5);
    step("alias_alloc", 1'b1, A, 1, 0, B, 0, B4, 1, TB,  1, T80, 1, TB,    6, 5);
    idle("alias_evict", A, 0, A4, 7, 6);
    idle("alias_hit", B, 1, TB, 7, 6);
    step("same_edge",   1'b1, B, 1, 0, B, 1, TB, 0, TB,  1, TB,  1, B4,    7, 6);
    idle("after_same_edge", B, 0, B4, 8, 7);
    step("pc_wrap", 1'b1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1, T, 0, T,
         0, 32'd0, 1, 32'd0, 8, 7);
    idle("after_wrap", B, 0, B4, 9, 8);
    force dut.branch_cnt_q  = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    step("sat_alloc",   1'b1, B, 1, 0, A, 0, A4, 1, T,   0, B4,  1, T,  M1, 32'hFFFF_FFFE);
    step("sat_hold",    1'b1, A, 1, 0, A, 0, A4, 1, T,   1, T,   1, T,  M1, M1);
    idle("sat_idle", A, 1, T, M1, M1);
    step("reset_mid",   1'b0, A, 1, 0, A, 0, A4, 1, T,   0, A4,  0, 32'd0, 0, 0);
    idle("after_reset", A, 0, A4, 0, 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending, exp 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
